// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage leading-zero normaliser with elastic valid/ready handshake.
// Define NORM_SUBNORMAL_EN for gradual underflow (shift limited to the exponent).
module norm_shift_pipe #(
  parameter int MAN_WIDTH = 24,
  parameter int EXP_WIDTH = 8,
  localparam int LZ_WIDTH = $clog2(MAN_WIDTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [MAN_WIDTH-1:0] man_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [MAN_WIDTH-1:0] man_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic [LZ_WIDTH-1:0]  lz_o,
  output logic                 zero_o,
  output logic                 uf_o
);
  localparam int CW = (EXP_WIDTH > LZ_WIDTH ? EXP_WIDTH : LZ_WIDTH) + 1;
  logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                 in_fire, s2_adv;
  logic [MAN_WIDTH-1:0] s1_man_q;
  logic [EXP_WIDTH-1:0] s1_exp_q;
  logic [LZ_WIDTH-1:0]  s1_lz_q, lz_d;
  logic                 s1_zero_q;
  logic [CW-1:0]        exp_x, lz_x;
  logic                 under;
  logic [LZ_WIDTH-1:0]  sh;
  logic [EXP_WIDTH-1:0] exp_n;
  logic [MAN_WIDTH-1:0] man_d, man_q;
  logic [EXP_WIDTH-1:0] exp_d, exp_q;
  logic [LZ_WIDTH-1:0]  lzo_d, lzo_q;
  logic                 zero_q, uf_d, uf_q;
  assign s2_adv  = s1_valid_q & (~s2_valid_q | ready_i);
  assign ready_o = ~s1_valid_q | s2_adv;
  assign in_fire = valid_i & ready_o;
  assign valid_o = s2_valid_q;
  assign s1_valid_d = in_fire ? 1'b1 : s2_adv ? 1'b0 : s1_valid_q;
  assign s2_valid_d = s2_adv ? 1'b1 : ready_i ? 1'b0 : s2_valid_q;
  // Highest set bit wins, so the last match in the ascending loop gives the count.
  always_comb begin
    lz_d = LZ_WIDTH'(MAN_WIDTH);
    for (int i = 0; i < MAN_WIDTH; i++)
      if (man_i[i]) lz_d = LZ_WIDTH'(MAN_WIDTH - 1 - i);
  end
  assign exp_x = CW'(s1_exp_q);
  assign lz_x  = CW'(s1_lz_q);
  assign under = lz_x > exp_x;
`ifdef NORM_SUBNORMAL_EN
  // exp < lz <= MAN_WIDTH here, so the exponent fits the shift width.
  assign sh    = under ? LZ_WIDTH'(s1_exp_q) : s1_lz_q;
  assign exp_n = EXP_WIDTH'(exp_x - CW'(sh));
`else
  assign sh    = s1_lz_q;
  assign exp_n = under ? '0 : EXP_WIDTH'(exp_x - lz_x);
`endif
  always_comb begin
    man_d = s1_zero_q ? '0 : s1_man_q << sh;
    exp_d = s1_zero_q ? '0 : exp_n;
    lzo_d = s1_zero_q ? LZ_WIDTH'(MAN_WIDTH) : sh;
    uf_d  = ~s1_zero_q & under;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      man_q      <= '0;
      exp_q      <= '0;
      lzo_q      <= '0;
      zero_q     <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s2_adv) begin
        man_q  <= man_d;
        exp_q  <= exp_d;
        lzo_q  <= lzo_d;
        zero_q <= s1_zero_q;
        uf_q   <= uf_d;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      s1_man_q  <= man_i;
      s1_exp_q  <= exp_i;
      s1_lz_q   <= lz_d;
      s1_zero_q <= man_i == '0;
    end
  end
  assign man_o  = man_q;
  assign exp_o  = exp_q;
  assign lz_o   = lzo_q;
  assign zero_o = zero_q;
  assign uf_o   = uf_q;
endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: directed bench for norm_shift_pipe with an arithmetic reference model.
module tb_norm_shift_pipe;
  localparam int MW = 8, EW = 6, LW = $clog2(MW + 1);
  logic clk = 0, rst = 1, valid_i = 0, ready_i = 1;
  logic [MW-1:0] man_i = '0;
  logic [EW-1:0] exp_i = '0;
  logic ready_o, valid_o, zero_o, uf_o;
  logic [MW-1:0] man_o;
  logic [EW-1:0] exp_o;
  logic [LW-1:0] lz_o;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    logic [LW-1:0] l;
    logic z;
    logic u;
  } res_t;
  res_t q[$];
  res_t cur, prev;
  logic stall = 0;

  norm_shift_pipe #(.MAN_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .man_i(man_i), .exp_i(exp_i), .valid_o(valid_o), .ready_i(ready_i),
    .man_o(man_o), .exp_o(exp_o), .lz_o(lz_o), .zero_o(zero_o), .uf_o(uf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic res_t model(input int m, input int e);
    int lz = 0, sh;
    res_t r;
    if (m == 0) begin
      r.m = '0; r.e = '0; r.l = LW'(MW); r.z = 1'b1; r.u = 1'b0;
      return r;
    end
    while (((m >> (MW - 1 - lz)) & 1) == 0) lz++;
`ifdef NORM_SUBNORMAL_EN
    sh = (lz > e) ? e : lz;
    r.e = EW'(e - sh);
`else
    sh = lz;
    r.e = (e >= lz) ? EW'(e - lz) : '0;
`endif
    r.m = MW'(m << sh);
    r.l = LW'(sh);
    r.z = 1'b0;
    r.u = lz > e;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall = 0;
    end else begin
      cur = '{m: man_o, e: exp_o, l: lz_o, z: zero_o, u: uf_o};
      if (valid_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious: valid_o=1 with no operand outstanding at %0t", $time);
        end else begin
          chk("model", 32'(cur), 32'(q[0]));
          if (ready_i) void'(q.pop_front());
        end
        if (stall) chk("stall_hold", 32'(cur), 32'(prev));
      end
      stall = valid_o && !ready_i;
      prev = cur;
      if (valid_i && ready_o) q.push_back(model(int'(man_i), int'(exp_i)));
    end
  end

  task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e);
    logic acc = 0;
    valid_i = 1; man_i = m; exp_i = e;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk) acc = ready_o;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready_o=0 expected 1");
    end
    valid_i = 0;
  endtask

  task automatic expect_out(input string name, input logic [MW-1:0] m, input logic [EW-1:0] e,
                            input logic [LW-1:0] l, input logic z, input logic u);
    for (int k = 0; k < 10 && !valid_o; k++) begin
      @(posedge clk); #1;
    end
    chk({name, "_valid"}, 32'(valid_o), 1);
    chk({name, "_res"}, {man_o, exp_o, lz_o, zero_o, uf_o}, {m, e, l, z, u});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [MW-1:0] sm [5] = '{8'h80, 8'h40, 8'h20, 8'h01, 8'hFF};
  logic [LW-1:0] sl [5] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd0};
  logic [EW-1:0] se [5] = '{6'd30, 6'd29, 6'd28, 6'd23, 6'd30};
  logic [MW-1:0] bm [5] = '{8'h30, 8'h05, 8'h81, 8'h02, 8'h11};
  logic [EW-1:0] be [5] = '{6'd12, 6'd9, 6'd3, 6'd1, 6'd63};
  logic          br [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [MW-1:0] mm [8] = '{8'h01, 8'h00, 8'hC3, 8'h08, 8'h7F, 8'h01, 8'h02, 8'h40};
  logic [EW-1:0] me [8] = '{6'd0, 6'd5, 6'd0, 6'd4, 6'd1, 6'd63, 6'd6, 6'd2};
  logic [39:0]   rpat = 40'hB5_3C_E6_9A_F1;

  initial begin
    int idx, n;
    logic acc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_ready_o", 32'(ready_o), 1);
    chk("rst_outputs", {man_o, exp_o, lz_o, zero_o, uf_o}, 0);
    rst = 0;
    idle(1);

    send(8'h10, 6'd10);
    chk("lat_first_edge", 32'(valid_o), 0);
    @(posedge clk); #1;
    chk("lat_second_edge", 32'(valid_o), 1);
    chk("basic_res", {man_o, exp_o, lz_o, zero_o, uf_o}, {8'h80, 6'd7, 4'd3, 1'b0, 1'b0});
    idle(2);

    send(8'h00, 6'd20);
    expect_out("zero", 8'h00, 6'd0, 4'd8, 1'b1, 1'b0);
    idle(1);

    send(8'h01, 6'd4);
`ifdef NORM_SUBNORMAL_EN
    expect_out("underflow", 8'h10, 6'd0, 4'd4, 1'b0, 1'b1);
`else
    expect_out("underflow", 8'h80, 6'd0, 4'd7, 1'b0, 1'b1);
`endif
    idle(2);

    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        valid_i = 1; man_i = sm[i]; exp_i = 6'd30;
        chk("stream_ready", 32'(ready_o), 1);
      end else valid_i = 0;
      @(posedge clk); #1;
      if (i >= 1) begin
        chk("stream_valid", 32'(valid_o), 1);
        chk("stream_lz_exp", {lz_o, exp_o}, {sl[i-1], se[i-1]});
      end
    end
    idle(3);

    ready_i = 0; idx = 0;
    for (int c = 0; c < 4; c++) begin
      valid_i = 1; man_i = bm[idx]; exp_i = be[idx];
      chk("bp_ready", 32'(ready_o), 32'(br[c]));
      @(negedge clk) acc = ready_o;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    valid_i = 0;
    chk("bp_accepted", idx, 2);
    ready_i = 1; n = 0;
    for (int c = 0; c < 5; c++) begin
      if (valid_o) n++;
      @(posedge clk); #1;
    end
    chk("bp_drained", n, 2);
    idle(2);

    ready_i = 0;
    for (int c = 0; c < 2; c++) begin
      valid_i = 1; man_i = bm[c+2]; exp_i = be[c+2];
      @(posedge clk); #1;
    end
    valid_i = 0;
    chk("pre_rst_full", {31'd0, valid_o & ~ready_o}, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; ready_i = 1;
    chk("midrst_valid_o", 32'(valid_o), 0);
    chk("midrst_ready_o", 32'(ready_o), 1);
    chk("midrst_outputs", {man_o, exp_o, lz_o, zero_o, uf_o}, 0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (valid_o) n++;
      @(posedge clk); #1;
    end
    chk("midrst_no_stale", n, 0);

    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      valid_i = 1; man_i = mm[idx]; exp_i = me[idx];
      ready_i = rpat[c];
      @(negedge clk) acc = ready_o;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    valid_i = 0; ready_i = 1;
    chk("mix_accepted", idx, 8);
    idle(6);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
